// File: rtl/speculative_issue_ctrl.sv
// Two-entry micro-op issue buffer between micro-code fetch and execution.
// Slot 0 is the oldest entry; a slot-0/slot-1 pair issues together when the judge reports no conflict.
module speculative_issue_ctrl #(
   parameter bit DUAL_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instruction,
   input  logic [31:0]      in_micro_code,
   output logic [31:0]      micro_code_normal,
   output logic [31:0]      micro_code_speculative,
   output logic [31:0]      instruction_normal,
   output logic [31:0]      instruction_speculative,
   input  logic             is_micro_code_not_conflict,
   input  logic             flush,
   output logic             issue_valid,
   output logic             issue_dual,
   input  logic             exec_ready,
   output logic [31:0]      issue_micro_code0,
   output logic [31:0]      issue_micro_code1,
   output logic [31:0]      issue_instruction0,
   output logic [31:0]      issue_instruction1,
   output logic [CNT_W-1:0] dual_issue_count,
   output logic [1:0]       state_dbg
);

   // Handshake: an op transfers on a cycle where in_valid && in_ready; a bundle
   // leaves the issue register on a cycle where issue_valid && exec_ready.
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t      state;
   logic [31:0] mc0, ins0, mc1, ins1;
   logic        load, dual, push;
   logic [1:0]  pop, rem;

   always_comb begin
      load     = (state != EMPTY) && (!issue_valid || exec_ready) && !flush;
      dual     = load && (state == TWO) && (DUAL_EN != 1'b0) && is_micro_code_not_conflict;
      pop      = dual ? 2'd2 : (load ? 2'd1 : 2'd0);
      in_ready = !flush && ((state != TWO) || load);
      push     = in_valid && in_ready;
      rem      = 2'(state) - pop;
   end

   assign micro_code_normal       = (state != EMPTY) ? mc0  : '0;
   assign instruction_normal      = (state != EMPTY) ? ins0 : '0;
   assign micro_code_speculative  = (state == TWO)   ? mc1  : '0;
   assign instruction_speculative = (state == TWO)   ? ins1 : '0;
   assign state_dbg               = 2'(state);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state              <= EMPTY;
         mc0                <= '0;
         ins0               <= '0;
         mc1                <= '0;
         ins1               <= '0;
         issue_valid        <= 1'b0;
         issue_dual         <= 1'b0;
         issue_micro_code0  <= '0;
         issue_micro_code1  <= '0;
         issue_instruction0 <= '0;
         issue_instruction1 <= '0;
         dual_issue_count   <= '0;
      end else if (flush) begin
         state       <= EMPTY;
         issue_valid <= 1'b0;
         issue_dual  <= 1'b0;
      end else begin
         state <= state_t'(rem + {1'b0, push});
         if (pop == 2'd1 && state == TWO) begin
            mc0  <= mc1;
            ins0 <= ins1;
         end
         // A pushed op lands in the first slot left free after this cycle's pop.
         if (push) begin
            if (rem == 2'd0) begin
               mc0  <= in_micro_code;
               ins0 <= in_instruction;
            end else begin
               mc1  <= in_micro_code;
               ins1 <= in_instruction;
            end
         end
         if (load) begin
            issue_micro_code0  <= mc0;
            issue_instruction0 <= ins0;
            issue_micro_code1  <= dual ? mc1  : '0;
            issue_instruction1 <= dual ? ins1 : '0;
            issue_valid        <= 1'b1;
            issue_dual         <= dual;
         end else if (exec_ready && issue_valid) begin
            issue_valid <= 1'b0;
            issue_dual  <= 1'b0;
         end
         if (dual && dual_issue_count != '1)
            dual_issue_count <= dual_issue_count + CNT_W'(1);
      end
   end

endmodule
